soc2_nios_oci_dct_sequencer: RTL and testbench

Sequencer for the Nios OCI data-compression-trace (DCT) path. Packs 2-bit trace symbols from the trace producer into the 30-bit DCT buffer (15 symbols) with a 4-bit symbol count. Emits each full or flushed buffer over a valid/ready handshake to the trace sink. Also drives the test-ending/test-has-ended sequence consumed by the OCI test bench.

---
 rtl/soc2_nios_oci_dct_sequencer.sv | 110 +++++++++++
 tb/tb_soc2_nios_oci_dct_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/soc2_nios_oci_dct_sequencer.sv
// Packs 2-bit trace symbols LSB-first into a 30-bit DCT buffer and emits full or flushed
// words over valid/ready. It also sequences the test-ending flush into a sticky test_has_ended.
module soc2_nios_oci_dct_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_data,
    input  logic [1:0]  in_nsym,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] out_data,
    output logic [3:0]  out_count,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    input  logic        test_ending,
    output logic        test_has_ended
);

    typedef enum logic [1:0] {S_FILL, S_EMIT, S_ENDED} state_e;

    state_e      state_q, state_d;
    logic [29:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;

    logic [4:0]  sum;
    logic        fits;
    logic        accept;
    logic        overflow;
    logic [5:0]  sym_mask;
    logic [29:0] ins;

    // Five-bit sum so that 15 + 3 cannot wrap and be mistaken for a fit.
    assign sum      = {1'b0, cnt_q} + {3'b000, in_nsym};
    assign fits     = (sum <= 5'd15);
    assign accept   = (state_q == S_FILL) && in_valid && fits;
    assign overflow = (state_q == S_FILL) && in_valid && !fits;

    always_comb begin
        case (in_nsym)
            2'd0:    sym_mask = 6'b000000;
            2'd1:    sym_mask = 6'b000011;
            2'd2:    sym_mask = 6'b001111;
            default: sym_mask = 6'b111111;
        endcase
    end

    // Bits above the live count are always zero, so OR-ing in the new symbols is enough.
    assign ins = {24'd0, in_data & sym_mask} << {cnt_q, 1'b0};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FILL;
            buf_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    buf_d = buf_q | ins;
                    cnt_d = sum[3:0];
                end
                if (test_ending) begin
                    flush_d = 1'b1;
                    state_d = (cnt_d != 4'd0) ? S_EMIT : S_ENDED;
                end else if (cnt_d == 4'd15 || overflow) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (test_ending) flush_d = 1'b1;
                if (out_ready) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = flush_d ? S_ENDED : S_FILL;
                end
            end
            S_ENDED: ;
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        in_ready       = (state_q == S_FILL) && fits;
        out_valid      = (state_q == S_EMIT);
        test_has_ended = (state_q == S_ENDED);
    end

    assign out_data   = buf_q;
    assign out_count  = cnt_q;
    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;

endmodule

// File: tb/tb_soc2_nios_oci_dct_sequencer.sv
// Directed and randomized bench for the DCT sequencer. The reference model holds the buffer
// as a queue of symbols and re-packs it on demand.
module tb_soc2_nios_oci_dct_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_data = '0;
    logic [1:0]  in_nsym = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending = 1'b0;
    logic        test_has_ended;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = collecting symbols, 1 = offering a word, 2 = finished.
    logic [1:0] sym_q[$];
    int         m_mode  = 0;
    bit         m_flush = 0;

    always #5 clk = ~clk;

    soc2_nios_oci_dct_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_nsym        (in_nsym),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] packed_word();
        logic [29:0] w = '0;
        for (int i = 0; i < sym_q.size(); i++) w[2*i +: 2] = sym_q[i];
        return w;
    endfunction

    task automatic check_all(input string tag);
        bit exp_ready;
        exp_ready = (m_mode == 0) && (sym_q.size() + int'(in_nsym) <= 15);
        check({tag, ".in_ready"},       {31'd0, in_ready},       {31'd0, exp_ready});
        check({tag, ".out_valid"},      {31'd0, out_valid},      {31'd0, m_mode == 1});
        check({tag, ".test_has_ended"}, {31'd0, test_has_ended}, {31'd0, m_mode == 2});
        check({tag, ".dct_count"},      {28'd0, dct_count},      sym_q.size());
        check({tag, ".dct_buffer"},     {2'd0, dct_buffer},      {2'd0, packed_word()});
        check({tag, ".out_count"},      {28'd0, out_count},      sym_q.size());
        check({tag, ".out_data"},       {2'd0, out_data},        {2'd0, packed_word()});
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit ovf = 0;
        logic [5:0] d;
        d = in_data;
        if (m_mode == 0) begin
            if (in_valid && sym_q.size() + int'(in_nsym) <= 15) begin
                for (int k = 0; k < int'(in_nsym); k++) sym_q.push_back(d[2*k +: 2]);
            end else if (in_valid) begin
                ovf = 1;
            end
            if (test_ending) begin
                m_flush = 1;
                m_mode  = (sym_q.size() != 0) ? 1 : 2;
            end else if (sym_q.size() == 15 || ovf) begin
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (test_ending) m_flush = 1;
            if (out_ready) begin
                sym_q.delete();
                m_mode = m_flush ? 2 : 0;
            end
        end
    endtask

    // One cycle: drive on the falling edge, check settled outputs, then let the rising edge apply.
    task automatic cycle(input string tag, input bit v, input logic [1:0] n, input logic [5:0] d,
                         input bit te, input bit ordy);
        @(negedge clk);
        in_valid    = v;
        in_nsym     = n;
        in_data     = d;
        test_ending = te;
        out_ready   = ordy;
        #1;
        check_all(tag);
        model_step();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset       = 1'b1;
        in_valid    = 1'b0;
        test_ending = 1'b0;
        out_ready   = 1'b0;
        in_nsym     = 2'd0;
        #1;
        sym_q.delete();
        m_mode  = 0;
        m_flush = 0;
        check_all(tag);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state.
        do_reset("reset0");

        // Five three-symbol accepts fill the buffer exactly.
        for (int i = 0; i < 5; i++) cycle("fill3", 1, 2'd3, 6'b111001, 0, 0);
        cycle("emit15", 0, 2'd0, 6'd0, 0, 0);
        check("plan1.word",  {2'd0, out_data}, 32'h39E79E79);
        check("plan1.count", {28'd0, out_count}, 32'd15);
        cycle("xfer15", 0, 2'd0, 6'd0, 0, 1);
        cycle("after15", 0, 2'd0, 6'd0, 0, 0);
        check("plan1.cleared", {28'd0, dct_count}, 32'd0);

        // Seven pairs, then an overflowing pair; out_ready held low ten cycles.
        for (int i = 0; i < 7; i++) cycle("fill2", 1, 2'd2, 6'(i + 5), 0, 0);
        cycle("ovf", 1, 2'd2, 6'b001011, 0, 0);
        check("plan2.ovf_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) cycle("hold", 1, 2'd2, 6'b001011, 0, 0);
        check("plan2.count14", {28'd0, out_count}, 32'd14);
        cycle("xfer14", 1, 2'd2, 6'b001011, 0, 1);
        cycle("retry", 1, 2'd2, 6'b001011, 0, 0);
        cycle("after_retry", 0, 2'd0, 6'd0, 0, 0);
        check("plan2.count2", {28'd0, dct_count}, 32'd2);

        // Flush with five symbols buffered.
        do_reset("reset1");
        cycle("f5a", 1, 2'd3, 6'b100111, 0, 0);
        cycle("f5b", 1, 2'd2, 6'b110110, 1, 0);
        cycle("f5emit", 0, 2'd0, 6'd0, 0, 0);
        check("plan3.count5", {28'd0, out_count}, 32'd5);
        cycle("f5xfer", 0, 2'd0, 6'd0, 0, 1);
        for (int i = 0; i < 3; i++) cycle("ended", 1, 2'd1, 6'd1, 1, 1);
        check("plan3.ended", {31'd0, test_has_ended}, 32'd1);

        // Flush with an empty buffer.
        do_reset("reset2");
        cycle("te_empty", 0, 2'd0, 6'd0, 1, 0);
        cycle("ended_empty", 0, 2'd0, 6'd0, 0, 0);
        check("plan4.ended", {31'd0, test_has_ended}, 32'd1);

        // Reset while a full word is being offered.
        do_reset("reset3");
        for (int i = 0; i < 5; i++) cycle("fill3b", 1, 2'd3, 6'b010011, 0, 0);
        cycle("emit_b", 0, 2'd0, 6'd0, 0, 0);
        do_reset("reset_mid_emit");
        cycle("post_reset", 1, 2'd3, 6'b000001, 0, 0);

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            if (m_mode == 2 && $urandom_range(3) == 0) begin
                do_reset("rnd_reset");
            end else begin
                cycle("rnd", 1'($urandom_range(3) != 0), 2'($urandom), 6'($urandom),
                      1'($urandom_range(59) == 0), 1'($urandom));
            end
        end
        cycle("final", 0, 2'd0, 6'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
